// File: rtl/pdp11_pkg.sv
// Shared PDP-11 datapath definitions: word widths, multiplier FSM encoding, abs helper.
// Latency: n/a (types, constants and a pure combinational function only).
// Backpressure: n/a.
package pdp11_pkg;

    localparam int WORD_W    = 16;
    localparam int DWORD_W   = 32;
    localparam int MUL_STEPS = 16;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_LAST = 2'd2,
        MUL_HOLD = 2'd3
    } mul_state_t;

    // Two's-complement magnitude of a 16-bit word. 0x8000 maps to 0x8000,
    // which is still correct when the result is treated as unsigned.
    function automatic logic [WORD_W-1:0] abs16(input logic [WORD_W-1:0] v);
        return v[WORD_W-1] ? (~v + 16'd1) : v;
    endfunction

endpackage

// File: rtl/mul1632.sv
// Sequential 16x16 signed multiplier (PDP-11 MUL), sign-magnitude shift-add, one partial product per clock.
// Latency: done pulses in the 17th cycle after the IDLE cycle in which ready is sampled high.
// Backpressure: ready is a level; a held ready parks the FSM in HOLD until it drops, so each operation gives one done.
//
// Ports:
//   clk          - system clock, all state changes on posedge
//   reset        - synchronous active-high reset, priority over ready
//   ready        - start request (level)
//   multiplicand - signed operand A, captured on the start edge only
//   multiplier   - signed operand B, captured on the start edge only
//   done         - one-cycle pulse, product/carry valid
//   product      - signed 32-bit product, stable until the next start edge
//   carry        - product does not fit in signed 16 bits
module mul1632
    import pdp11_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               ready,
    input  logic [WORD_W-1:0]  multiplicand,
    input  logic [WORD_W-1:0]  multiplier,
    output logic               done,
    output logic [DWORD_W-1:0] product,
    output logic               carry
);

    mul_state_t         r_state;
    mul_state_t         w_state_nxt;
    logic [WORD_W-1:0]  r_mag_a;
    logic [WORD_W-1:0]  r_mag_b;
    logic               r_neg;
    logic [DWORD_W-1:0] r_acc;
    logic [4:0]         r_count;

    logic [WORD_W:0]    w_sum;
    logic [DWORD_W-1:0] w_acc_neg;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MUL_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MUL_IDLE: if (ready)            w_state_nxt = MUL_RUN;
            MUL_RUN:  if (r_count == 5'd1)  w_state_nxt = MUL_LAST;
            MUL_LAST: w_state_nxt = ready ? MUL_HOLD : MUL_IDLE;
            MUL_HOLD: if (!ready)           w_state_nxt = MUL_IDLE;
            default:  w_state_nxt = MUL_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    // Partial product: add magA into the top half only when the current
    // multiplier bit is set; the 17th bit is the carry that re-enters at
    // bit 31 on the right shift.
    always_comb begin
        w_sum = {1'b0, r_acc[DWORD_W-1:WORD_W]};
        if (r_mag_b[0]) begin
            w_sum = {1'b0, r_acc[DWORD_W-1:WORD_W]} + {1'b0, r_mag_a};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_neg   <= 1'b0;
            r_acc   <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                MUL_IDLE: begin
                    if (ready) begin
                        r_mag_a <= abs16(multiplicand);
                        r_mag_b <= abs16(multiplier);
                        r_neg   <= multiplicand[WORD_W-1] ^ multiplier[WORD_W-1];
                        r_acc   <= '0;
                        r_count <= 5'(MUL_STEPS);
                    end
                end
                MUL_RUN: begin
                    r_acc   <= {w_sum, r_acc[WORD_W-1:1]};
                    r_mag_b <= r_mag_b >> 1;
                    r_count <= r_count - 5'd1;
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    // Negating a zero accumulator yields zero, so -0 never appears.
    assign w_acc_neg = ~r_acc + 32'd1;
    assign product   = r_neg ? w_acc_neg : r_acc;
    assign carry     = ~((product[DWORD_W-1:WORD_W-1] == 17'h0) ||
                         (product[DWORD_W-1:WORD_W-1] == 17'h1FFFF));
    assign done      = (r_state == MUL_LAST);

endmodule

// File: tb/tb_mul1632.sv
// Self-checking bench for mul1632: directed corner products, randomized operands, held-ready and mid-run reset.
// Latency: expects done in the 17th cycle after the sampling cycle.
// Backpressure: exercises ready held high (single done, park in HOLD) and ready re-arm after one low cycle.
module tb_mul1632;
    import pdp11_pkg::*;

    logic        clk;
    logic        reset;
    logic        ready;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic        done;
    logic [31:0] product;
    logic        carry;

    int total;
    int bad;

    mul1632 dut (
        .clk          (clk),
        .reset        (reset),
        .ready        (ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .done         (done),
        .product      (product),
        .carry        (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: plain signed integer arithmetic.
    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return 32'(sa * sb);
    endfunction

    function automatic logic ref_carry(input logic [15:0] a, input logic [15:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return (p > 32767) || (p < -32768);
    endfunction

    // Present operands with ready high and step through the sampling edge.
    // Returns just after that edge (first RUN cycle).
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        @(posedge clk); #1;
        ready        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(posedge clk); #1;
    endtask

    // Called in cycle 1 after the sampling edge; waits (bounded) for done,
    // checks latency and result. Returns at the negedge of the done cycle.
    task automatic finish_op(input string tag, input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 1;
        @(negedge clk);
        while (!done && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, " latency"}, 32'(n), 32'd17);
        check({tag, " product"}, product, ref_prod(a, b));
        check({tag, " carry"},   32'(carry), 32'(ref_carry(a, b)));
    endtask

    // Pulsed-ready operation with operand scrambling during RUN, then a
    // check that done is a single pulse and the result holds.
    task automatic pulse_op(input string tag, input logic [15:0] a, input logic [15:0] b);
        start_op(a, b);
        ready        = 1'b0;
        multiplicand = 16'($urandom);
        multiplier   = 16'($urandom);
        finish_op(tag, a, b);
        @(posedge clk); #1;
        multiplicand = 16'($urandom);
        @(negedge clk);
        check({tag, " done low after"}, 32'(done), 32'd0);
        check({tag, " product hold"},   product, ref_prod(a, b));
    endtask

    logic [15:0] dir_a [8];
    logic [15:0] dir_b [8];

    initial begin
        int ndone;
        logic [15:0] ra;
        logic [15:0] rb;

        total = 0;
        bad   = 0;
        reset = 1'b1;
        ready = 1'b0;
        multiplicand = 16'h1234;
        multiplier   = 16'h5678;

        dir_a = '{16'd3, 16'hFFFE, 16'h0100, 16'h8000, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};
        dir_b = '{16'd5, 16'd7,    16'h0080, 16'h0001, 16'h7FFF, 16'h8000, 16'h8000, 16'h0001};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset done",    32'(done),  32'd0);
        check("reset product", product,    32'd0);
        check("reset carry",   32'(carry), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed corners, absolute constants for the key ones.
        pulse_op("3x5", dir_a[0], dir_b[0]);
        check("3x5 abs", product, 32'h0000000F);
        pulse_op("m2x7", dir_a[1], dir_b[1]);
        check("m2x7 abs", product, 32'hFFFFFFF2);
        pulse_op("100x80", dir_a[2], dir_b[2]);
        check("100x80 carry abs", 32'(carry), 32'd1);
        pulse_op("8000x1", dir_a[3], dir_b[3]);
        check("8000x1 abs", product, 32'hFFFF8000);
        pulse_op("7fffsq", dir_a[4], dir_b[4]);
        check("7fffsq abs", product, 32'h3FFF0001);
        pulse_op("8000sq", dir_a[5], dir_b[5]);
        check("8000sq abs", product, 32'h40000000);
        pulse_op("0x8000", dir_a[6], dir_b[6]);
        check("0x8000 abs", product, 32'h00000000);
        pulse_op("m1x1", dir_a[7], dir_b[7]);

        // Randomized operands.
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 6 == 0) ra = 16'h8000;
            if (i % 7 == 0) rb = 16'(int'($urandom_range(0, 3)) - 2);
            pulse_op($sformatf("rnd%0d", i), ra, rb);
        end

        // Ready held high for 60 cycles: one done, then park in HOLD.
        ra = 16'hF00D;
        rb = 16'h0123;
        start_op(ra, rb);
        multiplicand = 16'($urandom);
        multiplier   = 16'($urandom);
        finish_op("held", ra, rb);
        ndone = 0;
        for (int i = 0; i < 42; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("held extra done", 32'(ndone), 32'd0);
        check("held state", 32'(dut.r_state), 32'(MUL_HOLD));
        check("held product", product, ref_prod(ra, rb));

        // Drop ready one cycle, re-raise: second operation starts.
        @(posedge clk); #1;
        ready        = 1'b0;
        ra           = 16'h0ABC;
        rb           = 16'hFF00;
        multiplicand = ra;
        multiplier   = rb;
        @(posedge clk); #1;
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        finish_op("rearm", ra, rb);

        // Reset in the 5th RUN cycle.
        start_op(16'h1357, 16'h2468);
        ready = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort state",   32'(dut.r_state), 32'(MUL_IDLE));
        check("abort product", product,    32'd0);
        check("abort carry",   32'(carry), 32'd0);
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("abort no done", 32'(ndone), 32'd0);
        pulse_op("m1xm1", 16'hFFFF, 16'hFFFF);
        check("m1xm1 abs", product, 32'h00000001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
